// File: rtl/frame_serializer_pkg.sv
// Shared CNN definitions: default frame geometry, serializer state encoding
// and the row-major word indexing helper.
package frame_serializer_pkg;

  localparam int DEF_ROWS   = 28;
  localparam int DEF_COLS   = 28;
  localparam int DEF_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } fs_state_e;

  // Row-major position of word (row, col) inside a frame of 'cols' columns.
  function automatic int word_index(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// Captures a packed frame on start and streams its words in row-major order
// over a valid/ready interface, with abort and a one-cycle done pulse.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ROWS*COLS*WORD_W-1:0] frame_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WORD_W-1:0]    out_data,
  output logic [$clog2(ROWS)-1:0]     out_row,
  output logic [$clog2(COLS)-1:0]     out_col,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int COL_W   = $clog2(COLS);
  localparam int FRAME_W = ROWS * COLS * WORD_W;
  localparam int BASE_W  = $clog2(FRAME_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  fs_state_e                 state_q, state_d;
  logic [FRAME_W-1:0]        frame_q, frame_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [WORD_W-1:0]  out_data_q, out_data_d;
  logic [ROW_W-1:0]          out_row_q, out_row_d;
  logic [COL_W-1:0]          out_col_q, out_col_d;
  logic                      out_last_q, out_last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      capture_s;
  logic                      load_s;
  logic                      clear_s;
  logic [ROW_W-1:0]          nxt_row_s, sel_row_s;
  logic [COL_W-1:0]          nxt_col_s, sel_col_s;
  int                        idx_s;
  logic [BASE_W-1:0]         base_s;

  // Next-state and next-output computation; outputs describe the word on the bus.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    capture_s   = 1'b0;
    load_s      = 1'b0;
    clear_s     = 1'b0;
    sel_row_s   = out_row_q;
    sel_col_s   = out_col_q;

    // Position following the word currently presented (column wraps into next row)
    if (out_col_q == COL_LAST) begin
      nxt_row_s = out_row_q + ROW_W'(1);
      nxt_col_s = '0;
    end else begin
      nxt_row_s = out_row_q;
      nxt_col_s = out_col_q + COL_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          capture_s = 1'b1;
          clear_s   = 1'b1;
          state_d   = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          clear_s = 1'b1;
          state_d = ST_IDLE;
        end else if (!out_valid_q) begin
          // First word after capture: position was cleared to (0,0)
          load_s = 1'b1;
        end else if (out_ready) begin
          if (out_last_q) begin
            clear_s = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            load_s    = 1'b1;
            sel_row_s = nxt_row_s;
            sel_col_s = nxt_col_s;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        clear_s = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        clear_s = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    idx_s  = word_index(32'(sel_row_s), 32'(sel_col_s), COLS);
    base_s = BASE_W'(idx_s * WORD_W);

    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = $signed(frame_q[base_s +: WORD_W]);
      out_row_d   = sel_row_s;
      out_col_d   = sel_col_s;
      out_last_d  = (sel_row_s == ROW_LAST) && (sel_col_s == COL_LAST);
    end else if (clear_s) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_row_d   = '0;
      out_col_d   = '0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (capture_s) begin
      frame_d = frame_in;
    end else begin
      frame_d = frame_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Control state and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Frame storage; contents are only meaningful after a capture, so no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed/randomized bench for frame_serializer with a row-major word-list model.
module tb_frame_serializer;

  localparam int ROWS = 28;
  localparam int COLS = 28;
  localparam int W    = 32;
  localparam int NW   = ROWS * COLS;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   abort;
  logic [NW*W-1:0]        frame_in;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [W-1:0]    out_data;
  logic [$clog2(ROWS)-1:0] out_row;
  logic [$clog2(COLS)-1:0] out_col;
  logic                   out_last;
  logic                   busy;
  logic                   done;

  int tests = 0;
  int fails = 0;
  int model [NW];
  int widx = 0;

  frame_serializer #(.ROWS(ROWS), .COLS(COLS), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_in(frame_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (word %0d)", tag, obs, exp, widx);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    for (int k = 0; k < NW; k++) frame_in[k*W +: W] = model[k];
  endtask

  task automatic random_frame();
    for (int k = 0; k < NW; k++) model[k] = int'($urandom());
    load_frame();
  endtask

  // Start a frame: nothing valid right after the start edge, word (0,0) one edge later.
  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    chk("busy_stream", 32'(busy), 32'd1);
    tick();
    chk("lat_first", 32'(out_valid), 32'd1);
    widx = 0;
  endtask

  // Transfer n words, checking each presented word against the model list.
  task automatic consume(input int n, input bit rnd);
    int got;
    int cyc;
    bit xfer;
    got = 0;
    cyc = 0;
    while (got < n && cyc < n * 16 + 64) begin
      if (!rnd) chk("no_bubble", 32'(out_valid), 32'd1);
      if (out_valid) begin
        chk("data", 32'(out_data), 32'(model[widx]));
        chk("row", 32'(out_row), 32'(widx / COLS));
        chk("col", 32'(out_col), 32'(widx % COLS));
        chk("last", 32'(out_last), 32'(widx == NW - 1));
      end
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      xfer = out_valid && out_ready;
      tick();
      if (xfer) begin
        widx++;
        got++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    chk("consume_count", 32'(got), 32'(n));
  endtask

  task automatic check_done();
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    tick();
    chk("done_once", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_row"}, 32'(out_row), 32'd0);
    chk({tag, "_col"}, 32'(out_col), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    frame_in = '0;
    #1 rst = 1'b1;
    #1;
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Counting frame r*100+c with a ready consumer
    for (int k = 0; k < NW; k++) model[k] = (k / COLS) * 100 + (k % COLS);
    load_frame();
    begin_frame();
    consume(NW, 1'b0);
    check_done();

    // Negative word held under backpressure
    random_frame();
    model[1] = -5;
    load_frame();
    begin_frame();
    consume(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_data", 32'(out_data), 32'hFFFF_FFFB);
      chk("hold_row", 32'(out_row), 32'd0);
      chk("hold_col", 32'(out_col), 32'd1);
      tick();
    end
    consume(NW - 1, 1'b0);
    check_done();

    // Random backpressure
    random_frame();
    begin_frame();
    consume(NW, 1'b1);
    check_done();

    // Restart attempt and frame_in change mid-stream are ignored
    random_frame();
    begin_frame();
    consume(100, 1'b0);
    start = 1'b1;
    frame_in = ~frame_in;
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    consume(NW - 100, 1'b1);
    check_done();

    // Abort wins over a simultaneous transfer
    random_frame();
    begin_frame();
    consume(300, 1'b0);
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(out_valid), 32'd0);
    random_frame();
    begin_frame();
    consume(NW, 1'b1);
    check_done();

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_valid", 32'(out_valid), 32'd0);
    tick();
    chk("sa_valid2", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-frame, then restart from (0,0)
    random_frame();
    begin_frame();
    consume(500, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    begin_frame();
    consume(NW, 1'b0);
    check_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter ROWS, default 28, frame row count.
REQ-002 Parameter COLS, default 28, frame column count.
REQ-003 Parameter WORD_W, default 32, signed word width.
REQ-004 clk  input  1  single clock; all state rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to capture and stream a frame.
REQ-007 abort  input  1  synchronous cancel of the current frame.
REQ-008 frame_in  input  ROWS*COLS*WORD_W  packed signed frame; word (r,c) at bit offset (r*COLS+c)*WORD_W.
REQ-009 out_valid  output  1  out_data holds a word.
REQ-010 out_ready  input  1  consumer accepts the word.
REQ-011 out_data  output  WORD_W  signed word (r,c).
REQ-012 out_row  output  clog2(ROWS)  row index of out_data.
REQ-013 out_col  output  clog2(COLS)  column index of out_data.
REQ-014 out_last  output  1  high with word (ROWS-1,COLS-1).
REQ-015 busy  output  1  high in STREAM and DONE.
REQ-016 done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-017 The block SHALL implement states IDLE, STREAM and DONE.
REQ-018 In IDLE, start=1 SHALL capture frame_in into an internal frame register, set row=col=0 and enter STREAM.
REQ-019 Latency: with start at edge N, out_valid SHALL be 1 with word (0,0) after edge N+1.
REQ-020 A transfer SHALL occur only on an edge where out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-022 On a transfer, col SHALL increment, wrap from COLS-1 to 0 and increment row, with the next word valid on the following cycle (no bubble).
REQ-023 Words SHALL stream in row-major order, ROWS*COLS transfers per frame, with no sign change or truncation.
REQ-024 out_last SHALL be 1 only when row=ROWS-1 and col=COLS-1 and out_valid=1.
REQ-025 A transfer of the last word SHALL drop out_valid next cycle and enter DONE; done=1 for exactly one cycle in DONE, then IDLE.
REQ-026 start outside IDLE SHALL be ignored; frame_in changes after capture SHALL NOT affect output.
REQ-027 abort=1 in STREAM or DONE SHALL return to IDLE next cycle with out_valid=0 and no done pulse; abort has priority over a simultaneous transfer.
REQ-028 start and abort both high in IDLE SHALL leave the block in IDLE.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, out_valid=0, out_last=0, done=0, busy=0, out_data=0, out_row=0, out_col=0, independent of clk.
REQ-030 rst asserted mid-frame SHALL discard the frame; the next start after release SHALL restart at (0,0).
REQ-031 The internal frame register does not require reset.

Structure
REQ-032 Default frame geometry (28, 28, 32) and the state encoding SHALL reside in the shared CNN package used by the loader and compute blocks.
REQ-033 The block SHALL be a single module with no sub-modules; word selection SHALL be an indexed part-select of the frame register.

Verification
REQ-034 Frame word (r,c)=r*100+c, out_ready=1 -> 784 consecutive valid cycles, first word 0, last word 2727 with out_last=1, done pulse one cycle later.
REQ-035 Word (0,1)=-5 (0xFFFFFFFB), out_ready low 3 cycles at that word -> out_data, out_row=0, out_col=1 held 3 cycles, then -5 transfers once.
REQ-036 Random out_ready (50%) -> 784 transfers in exact row-major order; no duplicates, no drops.
REQ-037 Second start at word 100 plus frame_in change -> ignored; stream continues with the originally captured words.
REQ-038 abort together with a transfer at word 300 -> out_valid=0 next cycle, state IDLE, no done; new start streams from (0,0).
REQ-039 rst pulse mid-cycle at word 500 -> outputs zero before the next clk edge; after release, idle until start.
